// File: rtl/alu_pipe.sv
// Pipelined ALU: single-pass ops flow through a LAT-deep register pipeline, while
// unsigned multiply runs on a sequential radix-2 shift-add unit sharing the output stage.
module alu_pipe #(
  parameter int WIDTH = 64,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out1,
  output logic             cf,
  output logic             zf,
  output logic             err
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int RES_W = 2*WIDTH + 3;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_NEG  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_R8   = 4'h8;
  localparam logic [3:0] OP_R9   = 4'h9;
  localparam logic [3:0] OP_RA   = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_PASS = 4'hC;
  localparam logic [3:0] OP_SWAP = 4'hD;
  localparam logic [3:0] OP_EQ   = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Result word layout: {err, zf, cf, out1, out}
  function automatic logic [RES_W-1:0] alu_eval(input logic [3:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             e;
    lo  = '0;
    hi  = '0;
    sum = '0;
    c   = 1'b0;
    e   = 1'b0;
    case (op)
      OP_AND:  lo = x & y;
      OP_OR:   lo = x | y;
      OP_XOR:  lo = x ^ y;
      OP_NOT:  lo = ~x;
      OP_NEG:  lo = '0 - x;
      OP_ADD: begin
        sum = {1'b0, x} + {1'b0, y};
        lo  = sum[WIDTH-1:0];
        c   = sum[WIDTH];
      end
      OP_SUB: begin
        lo = x - y;
        c  = (x < y);
      end
      OP_R8, OP_R9, OP_RA: e = 1'b1;
      OP_SHL:  lo = x << y[SH_W-1:0];
      OP_PASS: lo = x;
      OP_SWAP: begin
        lo = y;
        hi = x;
      end
      OP_EQ:   lo = (x == y) ? WIDTH'(1) : '0;
      default: lo = '0;
    endcase
    return {e, ({hi, lo} == '0), c, hi, lo};
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SH_W-1:0]      r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH:0]       w_psum;
  logic [2*WIDTH-1:0]   w_prod_nxt;
  logic                 w_mul_last;

  logic                 r_vld_po;
  logic [RES_W-1:0]     r_res_po;
  logic                 w_adv;
  logic                 w_is_mul;
  logic                 w_pipe_empty;
  logic                 w_acc;
  logic                 w_acc_sp;
  logic                 w_acc_mul;
  logic                 w_tail_vld;
  logic [RES_W-1:0]     w_tail_res;
  logic [RES_W-1:0]     w_res;

  assign w_adv     = !r_vld_po || out_ready;
  assign w_is_mul  = (opcode == OP_MUL);
  assign in_ready  = !rst && w_adv && (r_state == S_IDLE) && (!w_is_mul || w_pipe_empty);
  assign w_acc     = in_valid && in_ready;
  assign w_acc_sp  = w_acc && !w_is_mul;
  assign w_acc_mul = w_acc && w_is_mul;
  assign w_res     = alu_eval(opcode, a, b);

  // Stages p0 .. p(LAT-2): result computed on entry, then only carried forward
  generate
    if (LAT == 1) begin : g_direct
      assign w_tail_vld   = w_acc_sp;
      assign w_tail_res   = w_res;
      assign w_pipe_empty = !r_vld_po;
    end else begin : g_stages
      logic [LAT-2:0]   r_vld_p;
      logic [RES_W-1:0] r_res_p [LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_p <= '0;
        end else if (w_adv) begin
          r_vld_p[0] <= w_acc_sp;
          for (int i = 1; i < LAT-1; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_res_p[0] <= w_res;
          for (int i = 1; i < LAT-1; i++) r_res_p[i] <= r_res_p[i-1];
        end
      end

      assign w_tail_vld   = r_vld_p[LAT-2];
      assign w_tail_res   = r_res_p[LAT-2];
      assign w_pipe_empty = !r_vld_po && (r_vld_p == '0);
    end
  endgenerate

  // Multiplier: product register starts as {0, b}; each step adds a into the upper half and shifts right
  assign w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_psum, r_prod[WIDTH-1:1]};
  assign w_mul_last = (r_state == S_BUSY) && (r_cnt == SH_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc_mul)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_mul_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (w_acc_mul)          r_cnt <= '0;
    else if (r_state == S_BUSY)  r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_acc_mul) begin
      r_mcand <= a;
      r_prod  <= {{WIDTH{1'b0}}, b};
    end else if (r_state == S_BUSY) begin
      r_prod  <= w_prod_nxt;
    end
  end

  // Output stage: shared by the pipeline tail and the multiplier; the pipeline is empty whenever the multiplier finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_po <= 1'b0;
      r_res_po <= '0;
    end else if (w_mul_last) begin
      r_vld_po <= 1'b1;
      r_res_po <= {1'b0, (w_prod_nxt == '0), 1'b0, w_prod_nxt};
    end else if (w_adv) begin
      r_vld_po <= w_tail_vld;
      r_res_po <= w_tail_res;
    end
  end

  assign out_valid = r_vld_po;
  assign out       = r_res_po[WIDTH-1:0];
  assign out1      = r_res_po[2*WIDTH-1:WIDTH];
  assign cf        = r_res_po[2*WIDTH];
  assign zf        = r_res_po[2*WIDTH+1];
  assign err       = r_res_po[2*WIDTH+2];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe (WIDTH=64, LAT=3) with a scoreboard
// fed by an arithmetic reference model of each opcode.
module tb_alu_pipe;
  localparam int WIDTH = 64;
  localparam int LAT   = 3;

  typedef logic [2*WIDTH+2:0] res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out1;
  logic             cf;
  logic             zf;
  logic             err;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out1(out1), .cf(cf), .zf(zf), .err(err)
  );

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_acc = -1;
  int   last_out = -1;
  bit   acc_flag;
  res_t last_res;

  function automatic res_t mk(logic e, logic z, logic c, logic [63:0] hi, logic [63:0] lo);
    return {e, z, c, hi, lo};
  endfunction

  function automatic res_t model(logic [3:0] op, logic [63:0] x, logic [63:0] y);
    logic [63:0]  lo;
    logic [63:0]  hi;
    logic [127:0] p;
    logic         c;
    logic         e;
    lo = 64'd0; hi = 64'd0; p = 128'd0; c = 1'b0; e = 1'b0;
    case (op)
      4'd0:  lo = x & y;
      4'd1:  lo = x | y;
      4'd2:  lo = x ^ y;
      4'd3:  lo = ~x;
      4'd4:  lo = 64'd0 - x;
      4'd5:  begin p = {64'd0, x} + {64'd0, y}; lo = p[63:0]; c = p[64]; end
      4'd6:  begin lo = x - y; c = (x < y); end
      4'd7:  begin p = {64'd0, x} * {64'd0, y}; lo = p[63:0]; hi = p[127:64]; end
      4'd8, 4'd9, 4'd10: e = 1'b1;
      4'd11: lo = x << (y % 64);
      4'd12: lo = x;
      4'd13: begin lo = y; hi = x; end
      4'd14: lo = (x == y) ? 64'd1 : 64'd0;
      default: lo = 64'd0;
    endcase
    return {e, (lo == 64'd0 && hi == 64'd0), c, hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic peek();
    #1;
  endtask

  task automatic tick();
    #1;
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      exp_q.push_back(model(opcode, a, b));
      last_acc = cyc;
      acc_flag = 1'b1;
    end
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 136'(out_valid), 136'(0));
      end else begin
        chk("result", 136'({err, zf, cf, out1, out}), 136'(exp_q[0]));
        if (out_ready) begin
          last_res = {err, zf, cf, out1, out};
          void'(exp_q.pop_front());
          last_out = cyc;
          n_out++;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y, input int maxc);
    opcode = op; a = x; b = y; in_valid = 1'b1; acc_flag = 1'b0;
    for (int i = 0; i < maxc && !acc_flag; i++) tick();
    in_valid = 1'b0;
    chk("accept_timeout", 136'(acc_flag), 136'(1));
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (exp_q.size() == 0 && out_valid !== 1'b1) break;
      tick();
    end
    chk("drain", 136'(exp_q.size()), 136'(0));
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return ~64'd0;
      2: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0, hi_cnt, a2, sp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = 4'd0; a = '0; b = '0;
    @(negedge clk);
    repeat (3) tick();
    peek();
    chk("rst_in_ready", 136'(in_ready), 136'(0));
    chk("rst_out_valid", 136'(out_valid), 136'(0));
    chk("rst_outputs", 136'({err, zf, cf, out1, out}), 136'(0));
    rst = 1'b0;
    tick();

    // add overflow, latency LAT
    issue(4'd5, ~64'd0, 64'd1, 5);
    c0 = last_acc;
    drain(20);
    chk("add_latency", 136'(last_out - c0), 136'(3));
    chk("add_ovf", 136'(last_res), 136'(mk(1'b0, 1'b1, 1'b1, 64'd0, 64'd0)));

    // sub borrow, back-to-back, then backpressure
    n0 = n_out;
    issue(4'd6, 64'd5, 64'd7, 5);
    c0 = last_acc;
    issue(4'd0, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 5);
    issue(4'd1, 64'h1111_0000_2222_0000, 64'h0000_3333_0000_4444, 5);
    issue(4'd2, 64'hAAAA_5555_AAAA_5555, 64'hFFFF_0000_FFFF_0000, 5);
    chk("b2b_throughput", 136'(last_acc - c0), 136'(3));
    chk("sub_borrow", 136'(last_res), 136'(mk(1'b0, 1'b0, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE)));
    out_ready = 1'b0; opcode = 4'd5; a = 64'd100; b = 64'd23; in_valid = 1'b1; acc_flag = 1'b0;
    peek();
    chk("stall_in_ready", 136'(in_ready), 136'(0));
    repeat (4) tick();
    chk("stall_no_accept", 136'(acc_flag), 136'(0));
    out_ready = 1'b1;
    issue(4'd5, 64'd100, 64'd23, 20);
    drain(30);
    chk("stall_delivered", 136'(n_out - n0), 136'(5));

    // multiply latency WIDTH+1 with in_ready low throughout
    issue(4'd7, 64'h444F, 64'hFFFE, 5);
    c0 = last_acc;
    opcode = 4'd5; hi_cnt = 0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      peek();
      if (in_ready) hi_cnt++;
      tick();
    end
    chk("mul_in_ready_low", 136'(hi_cnt), 136'(0));
    chk("mul_latency", 136'(last_out - c0), 136'(65));
    chk("mul_result", 136'(last_res), 136'(mk(1'b0, 1'b0, 1'b0, 64'd0, 64'h444E_7762)));
    opcode = 4'd7;
    peek();
    chk("idle_after_mul", 136'(in_ready), 136'(1));

    // multiply behind two in-flight adds
    issue(4'd5, 64'd3, 64'd4, 5);
    issue(4'd5, 64'd10, 64'd20, 5);
    a2 = last_acc;
    opcode = 4'd7; a = 64'd6; b = 64'd7; in_valid = 1'b1;
    peek();
    chk("mul_blocked", 136'(in_ready), 136'(0));
    issue(4'd7, 64'd6, 64'd7, 20);
    chk("mul_after_adds", 136'(last_acc >= a2 + LAT), 136'(1));
    drain(200);
    chk("mul_last_out", 136'(last_res), 136'(mk(1'b0, 1'b0, 1'b0, 64'd0, 64'd42)));

    // reserved opcode and swap
    issue(4'd9, 64'h1234, 64'h5678, 5);
    drain(20);
    chk("reserved", 136'(last_res), 136'(mk(1'b1, 1'b1, 1'b0, 64'd0, 64'd0)));
    issue(4'd13, 64'd1, 64'd2, 5);
    drain(20);
    chk("swap", 136'(last_res), 136'(mk(1'b0, 1'b0, 1'b0, 64'd1, 64'd2)));

    // reset mid-multiply discards the product
    issue(4'd7, 64'hDEAD_BEEF, 64'h1234_5678, 5);
    repeat (10) tick();
    rst = 1'b1;
    peek();
    chk("rst_in_ready_mid", 136'(in_ready), 136'(0));
    tick();
    chk("rst_out_valid_mid", 136'(out_valid), 136'(0));
    exp_q.delete();
    rst = 1'b0; opcode = 4'd7; in_valid = 1'b0;
    peek();
    chk("ready_after_rst", 136'(in_ready), 136'(1));
    sp = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid === 1'b1) sp++;
      tick();
    end
    chk("no_stale_result", 136'(sp), 136'(0));

    // randomized traffic with random backpressure
    n0 = n_out;
    for (int n = 0; n < 700; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 4'($urandom_range(0, 15));
      a         = rnd64();
      b         = ($urandom_range(0, 3) == 0) ? a : rnd64();
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(400);
    chk("random_progress", 136'(n_out - n0 > 50), 136'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; legal values: powers of two, 8 or more.
REQ-002 SHALL have parameter LAT, default 3, pipeline depth for single-pass ops; legal values: 1 or more.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1: operation accepted on a clk edge where both are high.
REQ-006 SHALL have ports a, b  input  WIDTH  operands; opcode  input  4  operation select.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1: result consumed on a clk edge where both are high.
REQ-008 SHALL have ports out  output  WIDTH  primary result; out1  output  WIDTH  secondary/high result.
REQ-009 SHALL have ports cf, zf, err  output  1 each  carry/borrow, zero, illegal-opcode flags; all held with out.

Function
REQ-010 SHALL implement opcodes: 0000 a&b; 0001 a|b; 0010 a^b; 0011 ~a; 0100 two's complement -a; 0101 a+b; 0110 a-b.
REQ-011 SHALL implement: 0111 unsigned a*b, {out1,out} = 2*WIDTH product; 1011 logical left shift of a by b[log2(WIDTH)-1:0]; 1100 out=a.
REQ-012 SHALL implement: 1101 swap, out=b, out1=a; 1110 out=1 if a==b else 0; 1111 nop, out=0.
REQ-013 SHALL treat 1000, 1001, 1010 as reserved: out=0, out1=0, err=1. err SHALL be 0 for all other opcodes.
REQ-014 SHALL drive out1=0 for every opcode except 0111 and 1101.
REQ-015 SHALL set cf = carry-out for 0101 and borrow (a<b unsigned) for 0110; cf=0 otherwise.
REQ-016 SHALL set zf=1 iff {out1,out}==0, including nop.
REQ-017 Every opcode except 0111 SHALL traverse a LAT-stage pipeline: out_valid asserts exactly LAT cycles after acceptance when there is no backpressure.
REQ-018 Pipeline SHALL advance only when !out_valid || out_ready. Otherwise every stage holds; no result is lost or duplicated.
REQ-019 in_ready SHALL be high only when the pipeline advances this cycle, mul FSM is IDLE, and rst is low. For opcode 0111 it additionally requires all pipeline stages empty.
REQ-020 Results SHALL emerge in acceptance order; out/out1/flags SHALL be stable while out_valid && !out_ready.
REQ-021 Multiply SHALL use a sequential radix-2 shift-add unit with FSM states IDLE -> BUSY (WIDTH cycles) -> DONE.
REQ-022 DONE SHALL load the output register, with out_valid asserted WIDTH+1 cycles after acceptance, and hold until out_ready. Then return to IDLE.
REQ-023 in_ready SHALL be 0 while the FSM is BUSY or DONE.
REQ-024 Back-to-back single-pass ops SHALL sustain one acceptance per cycle when out_ready is held high.

Reset
REQ-025 While rst is high, on each clk edge: all stage valids cleared; FSM to IDLE; out, out1, cf, zf, err, out_valid = 0.
REQ-026 in_ready SHALL be 0 during rst. Reset mid-pipeline or mid-multiply SHALL discard in-flight work with no later out_valid for it.

Verification (WIDTH=64, LAT=3)
REQ-027 add a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> out=0, cf=1, zf=1, out_valid exactly 3 cycles after accept.
REQ-028 sub a=5, b=7 -> out=0xFFFF_FFFF_FFFF_FFFE, cf=1, zf=0. Then 4 back-to-back ops with out_ready low from second result -> in_ready drops, all 4 results delivered in order once out_ready returns.
REQ-029 mul a=0x444F, b=0xFFFE -> out=0x444E_7762, out1=0, out_valid 65 cycles after accept, in_ready low throughout.
REQ-030 mul presented behind two in-flight adds -> in_ready low until both adds drain; output order add, add, mul.
REQ-031 opcode 1001 -> out=0, out1=0, err=1, zf=1. swap a=1, b=2 -> out=2, out1=1, err=0.
REQ-032 rst pulsed 10 cycles into a mul -> next cycle out_valid=0, FSM IDLE, in_ready=1 after rst falls, no stale result appears.
